// File: rtl/button_conditioner.sv
// Button conditioner: synchronize, debounce and edge-detect raw buttons,
// then arbitrate single-cell moves on the nine board-cell buttons.
module button_conditioner #(
    parameter int DB_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] btn_raw,
    output logic [10:0] btn_level,
    output logic [10:0] btn_press,
    output logic        cell_valid,
    output logic [3:0]  cell_idx,
    output logic        multi_err
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [10:0]         sync1;
    logic [10:0]         sync2;
    logic [10:0][CW-1:0] cnt;
    logic [10:0][CW-1:0] cnt_nxt;
    logic [10:0]         level_nxt;

    logic [8:0] pc;
    logic [8:0] other;
    logic       any_press;
    logic       one_press;
    logic       accept;
    logic       reject;
    logic [3:0] idx_nxt;

    // two-flop synchronizer on every raw input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // per-bit stability counter; level flips after a full window of disagreement
    always_comb begin
        level_nxt = btn_level;
        cnt_nxt   = '0;
        for (int i = 0; i < 11; i++) begin
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // debounced level, counters and rising-edge pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
            btn_press <= level_nxt & ~btn_level;
        end
    end

    // classify this cycle's cell presses as accepted or ambiguous
    always_comb begin
        pc        = btn_press[8:0];
        other     = btn_level[8:0] & ~pc;
        any_press = (pc != 9'd0);
        one_press = any_press && ((pc & (pc - 9'd1)) == 9'd0);
        accept    = one_press && (other == 9'd0);
        reject    = any_press && !accept;
        idx_nxt   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (pc[i]) begin
                idx_nxt = 4'(i);
            end
        end
    end

    // registered arbitration outputs; index holds between accepted moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_valid <= 1'b0;
            multi_err  <= 1'b0;
            cell_idx   <= 4'd0;
        end else begin
            cell_valid <= accept;
            multi_err  <= reject;
            if (accept) begin
                cell_idx <= idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus randomized
// stimulus checked against a history-window reference model.
module tb_button_conditioner;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] btn_raw = '0;
    logic [10:0] btn_level;
    logic [10:0] btn_press;
    logic        cell_valid;
    logic [3:0]  cell_idx;
    logic        multi_err;

    int vecs = 0;
    int errs = 0;

    // reference model state
    logic [10:0] h[$];
    logic [10:0] m_level;
    logic [10:0] m_press;
    logic        m_cv;
    logic [3:0]  m_ci;
    logic        m_me;

    button_conditioner #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .cell_valid(cell_valid),
        .cell_idx(cell_idx),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        h.delete();
        for (int j = 0; j <= DB; j++) h.push_back(11'd0);
        m_level = '0;
        m_press = '0;
        m_cv = 1'b0;
        m_ci = 4'd0;
        m_me = 1'b0;
    endtask

    // Level flips when the synchronized input (raw from two edges ago)
    // has disagreed with the level for the last DB consecutive edges.
    task automatic model_edge(input logic [10:0] r);
        logic [8:0]  pp;
        logic [8:0]  oth;
        logic [10:0] nl;
        int          n;
        bit          all;
        pp = m_press[8:0];
        oth = m_level[8:0] & ~pp;
        n = $countones(pp);
        m_cv = (n == 1) && (oth == 0);
        m_me = (n >= 2) || ((n == 1) && (oth != 0));
        if (m_cv)
            for (int i = 0; i < 9; i++) if (pp[i]) m_ci = 4'(i);
        nl = m_level;
        for (int i = 0; i < 11; i++) begin
            all = 1;
            for (int j = 1; j <= DB; j++)
                if (h[j][i] == m_level[i]) all = 0;
            if (all) nl[i] = ~m_level[i];
        end
        m_press = nl & ~m_level;
        m_level = nl;
        h.push_front(r);
        void'(h.pop_back());
    endtask

    task automatic step(input logic [10:0] r);
        btn_raw = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic do_reset(input logic [10:0] r);
        btn_raw = r;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(11'h7ff);
        vecs++;
        if ({btn_level, btn_press, cell_valid, cell_idx, multi_err} !== 28'd0) begin
            errs++;
            $display("FAIL reset_state got %h exp 0",
                {btn_level, btn_press, cell_valid, cell_idx, multi_err});
        end
        do_reset(11'd0);
    endtask

    task automatic test_press_cell();
        for (int k = 1; k <= 8; k++) begin
            step(11'h010);
            vecs++;
            if ({btn_level, btn_press, cell_valid, cell_idx, multi_err} !==
                {m_level, m_press, m_cv, m_ci, m_me}) begin
                errs++;
                $display("FAIL press_cell_model k=%0d got %h exp %h", k,
                    {btn_level, btn_press, cell_valid, cell_idx, multi_err},
                    {m_level, m_press, m_cv, m_ci, m_me});
            end
            if (k == 5 || k == 6) begin
                vecs++;
                if (btn_level[4] !== (k == 6) || btn_press !== (k == 6 ? 11'h010 : 11'h0)) begin
                    errs++;
                    $display("FAIL press_cell_edge k=%0d lvl=%b press=%h", k,
                        btn_level[4], btn_press);
                end
            end
            if (k == 7) begin
                vecs++;
                if (cell_valid !== 1'b1 || cell_idx !== 4'd4 || multi_err !== 1'b0) begin
                    errs++;
                    $display("FAIL press_cell_accept cv=%b idx=%0d me=%b exp 1 4 0",
                        cell_valid, cell_idx, multi_err);
                end
            end
        end
        repeat (8) step(11'd0);
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 10; k++) begin
            step(k <= 3 ? 11'h004 : 11'h000);
            vecs++;
            if ({btn_level, btn_press, cell_valid, multi_err} !== 24'd0 ||
                {btn_level, btn_press, cell_valid, multi_err} !== {m_level, m_press, m_cv, m_me}) begin
                errs++;
                $display("FAIL glitch k=%0d got %h exp 0", k,
                    {btn_level, btn_press, cell_valid, multi_err});
            end
        end
    endtask

    task automatic test_simultaneous();
        int np = 0;
        int nme = 0;
        int ncv = 0;
        for (int k = 1; k <= 9; k++) begin
            step(11'h082);
            if (btn_press == 11'h082) np++;
            if (multi_err) nme++;
            if (cell_valid) ncv++;
            if (k == 7) begin
                vecs++;
                if (multi_err !== 1'b1 || cell_valid !== 1'b0 || cell_idx !== 4'd4) begin
                    errs++;
                    $display("FAIL simul_reject me=%b cv=%b idx=%0d exp 1 0 4",
                        multi_err, cell_valid, cell_idx);
                end
            end
        end
        vecs++;
        if (np != 1 || nme != 1 || ncv != 0) begin
            errs++;
            $display("FAIL simul_counts press=%0d me=%0d cv=%0d exp 1 1 0", np, nme, ncv);
        end
        repeat (8) step(11'd0);
    endtask

    task automatic test_overlap();
        int ncv = 0;
        int nme = 0;
        int np8 = 0;
        bit prev8 = 0;
        for (int k = 1; k <= 20; k++) begin
            step(k <= 9 ? 11'h001 : 11'h101);
            if (cell_valid) ncv++;
            if (multi_err) nme++;
            if (btn_press[8]) np8++;
            if (prev8) begin
                vecs++;
                if (multi_err !== 1'b1 || cell_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL overlap_reject me=%b cv=%b exp 1 0", multi_err, cell_valid);
                end
            end
            prev8 = btn_press[8];
        end
        vecs++;
        if (ncv != 1 || nme != 1 || np8 != 1 || cell_idx !== 4'd0) begin
            errs++;
            $display("FAIL overlap_counts cv=%0d me=%0d p8=%0d idx=%0d exp 1 1 1 0",
                ncv, nme, np8, cell_idx);
        end
        repeat (8) step(11'd0);
    endtask

    task automatic test_control();
        int n9 = 0;
        int n10 = 0;
        int bad = 0;
        for (int k = 1; k <= 24; k++) begin
            step(k <= 8 ? 11'h400 : (k <= 16 ? 11'h600 : 11'h000));
            if (btn_press[9]) n9++;
            if (btn_press[10]) n10++;
            if (cell_valid || multi_err) bad++;
            if (k == 21 || k == 22) begin
                vecs++;
                if (btn_level[10:9] !== (k == 21 ? 2'b11 : 2'b00) || btn_press !== 11'd0) begin
                    errs++;
                    $display("FAIL control_release k=%0d lvl=%b press=%h", k,
                        btn_level[10:9], btn_press);
                end
            end
        end
        vecs++;
        if (n9 != 1 || n10 != 1 || bad != 0) begin
            errs++;
            $display("FAIL control_counts p9=%0d p10=%0d cellout=%0d exp 1 1 0", n9, n10, bad);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step(11'h008);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        vecs++;
        if ({btn_level, btn_press, cell_valid, cell_idx, multi_err} !== 28'd0) begin
            errs++;
            $display("FAIL reset_async got %h exp 0",
                {btn_level, btn_press, cell_valid, cell_idx, multi_err});
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(11'h008);
            vecs++;
            if ({btn_level, btn_press, cell_valid, cell_idx, multi_err} !==
                {m_level, m_press, m_cv, m_ci, m_me}) begin
                errs++;
                $display("FAIL reset_mid_model k=%0d got %h exp %h", k,
                    {btn_level, btn_press, cell_valid, cell_idx, multi_err},
                    {m_level, m_press, m_cv, m_ci, m_me});
            end
            if (k == 5 || k == 6) begin
                vecs++;
                if (btn_level[3] !== (k == 6)) begin
                    errs++;
                    $display("FAIL reset_mid_level k=%0d got %b", k, btn_level[3]);
                end
            end
            if (k == 7) begin
                vecs++;
                if (cell_valid !== 1'b1 || cell_idx !== 4'd3) begin
                    errs++;
                    $display("FAIL reset_mid_accept cv=%b idx=%0d exp 1 3", cell_valid, cell_idx);
                end
            end
        end
        repeat (8) step(11'd0);
    endtask

    task automatic test_random();
        logic [10:0] r = '0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(3) == 0) r[$urandom_range(10)] ^= 1'b1;
            if ($urandom_range(40) == 0) r = '0;
            step(r);
            vecs++;
            if ({btn_level, btn_press, cell_valid, cell_idx, multi_err} !==
                {m_level, m_press, m_cv, m_ci, m_me}) begin
                errs++;
                $display("FAIL random k=%0d raw=%h got %h exp %h", k, r,
                    {btn_level, btn_press, cell_valid, cell_idx, multi_err},
                    {m_level, m_press, m_cv, m_ci, m_me});
            end
            vecs++;
            if (cell_valid && multi_err) begin
                errs++;
                $display("FAIL random_exclusive k=%0d cv=1 me=1", k);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_cell();
        test_glitch();
        test_simultaneous();
        test_overlap();
        test_control();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 50000, debounce stability window in clk cycles; legal range 2..2^20; counter width is $clog2(DB_CYCLES).
REQ-002 clk  input  1  single clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 btn_raw  input  11  raw pushbuttons, asynchronous to clk: [8:0] board cells 0-8, [9] player_sel, [10] start.
REQ-005 btn_level  output  11  debounced level of each button.
REQ-006 btn_press  output  11  one-cycle pulse on each debounced rising edge.
REQ-007 cell_valid  output  1  one-cycle pulse marking an accepted single-cell move.
REQ-008 cell_idx  output  4  index 0-8 of the accepted cell; qualified by cell_valid.
REQ-009 multi_err  output  1  one-cycle pulse marking a rejected (ambiguous) cell press.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each bit SHALL have an independent debounce counter; the synchronized bit differing from btn_level -> counter increments each cycle; synchronized bit equal to btn_level -> counter reset to 0.
REQ-012 When the counter equals DB_CYCLES-1 and the synchronized bit still differs, btn_level SHALL take the synchronized value and the counter SHALL return to 0.
REQ-013 Total latency: with raw stable, btn_level changes on the (DB_CYCLES+2)th rising clk edge after the raw change, for both press and release.
REQ-014 A raw pulse or glitch lasting fewer than DB_CYCLES synchronized cycles SHALL NOT change btn_level.
REQ-015 btn_press[i] SHALL be high for exactly the first cycle btn_level[i] reads 1; no pulse on release; no repeat while held.
REQ-016 Cell arbitration covers bits [8:0] only; bits 9 and 10 never affect cell_valid, cell_idx or multi_err.
REQ-017 In a cycle with exactly one btn_press[8:0] set and no other btn_level[8:0] bit already high, the block SHALL assert cell_valid on the next cycle with cell_idx = that bit index.
REQ-018 In a cycle with two or more btn_press[8:0] bits set, or a btn_press[8:0] bit set while a different btn_level[8:0] bit is already high, the block SHALL assert multi_err on the next cycle and SHALL NOT assert cell_valid.
REQ-019 cell_idx SHALL hold its last accepted value when cell_valid is low.
REQ-020 cell_valid and multi_err SHALL never be high in the same cycle.
REQ-021 All outputs are registered; no combinational path from btn_raw to any output.

Reset
REQ-022 On reset assertion, the following SHALL all go to 0 asynchronously: synchronizers, counters, btn_level, btn_press, cell_valid, cell_idx, multi_err.
REQ-023 Reset mid-count SHALL discard partial debounce progress.
REQ-024 A button held through reset release SHALL be treated as a new press: btn_level rises DB_CYCLES+2 edges after reset deassertion, with btn_press and cell arbitration as normal.
REQ-025 Reset deassertion SHALL be used synchronously to clk by the consuming logic; this block performs no reset synchronization.

Verification (DB_CYCLES=4)
REQ-026 Press cell: reset, then btn_raw[4]=1 held -> btn_level[4]=1 on edge 6; btn_press[4] pulses that cycle; next cycle cell_valid=1, cell_idx=4; multi_err stays 0.
REQ-027 Glitch rejection: btn_raw[2] high for 3 cycles then low -> btn_level, btn_press, cell_valid, multi_err all stay 0.
REQ-028 Simultaneous press: btn_raw[1] and btn_raw[7] rise on the same edge -> both btn_press pulse together; next cycle multi_err=1, cell_valid=0, cell_idx unchanged.
REQ-029 Overlapping press: hold cell 0 until accepted, then press cell 8 while still holding 0 -> btn_press[8] pulses; multi_err=1 next cycle; no cell_valid.
REQ-030 Control buttons: press btn_raw[10], then btn_raw[9] -> btn_press[10] and btn_press[9] each pulse once; cell_valid and multi_err stay 0; release -> btn_level falls on edge 6, no pulse.
REQ-031 Reset mid-operation: hold btn_raw[3], assert reset after 3 edges -> all outputs 0 during reset; release reset with button held -> btn_level[3] rises 6 edges later, then cell_valid=1, cell_idx=3.
